logic_unit_arbiter: RTL and testbench

//  Shares one combinational bitwise logic unit (AND/OR/XOR/NAND) between NREQ requesters.

---
 rtl/logic_unit_pkg.sv | 17 +
 rtl/logic_op_unit.sv | 24 ++
 rtl/logic_unit_arbiter.sv | 157 +++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared types for the logic-unit arbiter: opcode and FSM state encodings.
package logic_unit_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

endpackage

// File: rtl/logic_op_unit.sv
// Combinational bitwise gate datapath: y = op(a, b), no carries between bits.
module logic_op_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] y
);

    // Decode opcode into the selected bitwise function.
    always_comb begin
        y = '0;
        unique case (op_e'(op))
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic_op_unit between NREQ requesters.
// Each operation is serialised: accept (IDLE) -> execute (EXEC) -> respond (RESP).
module logic_unit_arbiter
    import logic_unit_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NREQ   = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ*2-1:0]       req_op,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_y,
    output logic [IDW-1:0]          rsp_id,
    output logic                    busy
);

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] rsp_y_q;
    logic [IDW-1:0]   rsp_id_q;
    logic             rsp_valid_q;

    logic [2*NREQ-1:0] valid_dbl;
    logic [NREQ-1:0]   valid_rot;
    logic [IDW:0]      idx_sum;
    logic              found;
    logic [IDW-1:0]    winner;
    logic [WIDTH-1:0]  sel_a, sel_b;
    logic [1:0]        sel_op;
    logic [WIDTH-1:0]  alu_y;
    logic              accept;

    // Rotate requests so rr_ptr sits at bit 0, take the first set bit and map it back.
    always_comb begin
        valid_dbl = {req_valid, req_valid};
        valid_rot = NREQ'(valid_dbl >> rr_ptr_q);
        found     = 1'b0;
        winner    = '0;
        idx_sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && valid_rot[k]) begin
                found   = 1'b1;
                idx_sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
                if (idx_sum >= (IDW+1)'(NREQ)) begin
                    idx_sum = idx_sum - (IDW+1)'(NREQ);
                end
                winner = idx_sum[IDW-1:0];
            end
        end
    end

    assign accept = (state_q == IDLE) && found;

    // Select the winner's operands and drive its one-hot accept strobe.
    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        sel_op    = '0;
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (winner == IDW'(k)) begin
                sel_a        = req_a[k*WIDTH +: WIDTH];
                sel_b        = req_b[k*WIDTH +: WIDTH];
                sel_op       = req_op[k*2 +: 2];
                req_ready[k] = accept;
            end
        end
    end

    logic_op_unit #(
        .WIDTH (WIDTH)
    ) u_op (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (alu_y)
    );

    // Next-state logic; the pointer only advances once the response is handed off.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d  = IDLE;
                    rr_ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Operand capture on accept, result registration in EXEC, release on handoff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            id_q        <= '0;
            rsp_y_q     <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                a_q  <= sel_a;
                b_q  <= sel_b;
                op_q <= sel_op;
                id_q <= winner;
            end
            if (state_q == EXEC) begin
                rsp_y_q     <= alu_y;
                rsp_id_q    <= id_q;
                rsp_valid_q <= 1'b1;
            end else if ((state_q == RESP) && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural model of pending requests, round-robin priority and gate results.
module tb_logic_unit_arbiter;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N*2-1:0] req_op;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_y;
    logic [1:0]     rsp_id;
    logic           busy;

    logic_unit_arbiter #(
        .WIDTH (W),
        .NREQ  (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    bit         pend [N];
    logic [7:0] ma   [N];
    logic [7:0] mb   [N];
    logic [1:0] mop  [N];
    int         mptr;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_fail   = 0;
    logic [3:0] last_grant;
    logic [7:0] last_y;
    logic [1:0] last_id;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] op);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    function automatic int model_winner();
        for (int k = 0; k < N; k++) begin
            if (pend[(mptr + k) % N]) return (mptr + k) % N;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = pend[i];
            req_a[i*W +: W]    = ma[i];
            req_b[i*W +: W]    = mb[i];
            req_op[i*2 +: 2]   = mop[i];
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            ma[i]   = '0;
            mb[i]   = '0;
            mop[i]  = '0;
        end
    endtask

    // One full transaction starting in IDLE at posedge+1; ends back in IDLE at posedge+1.
    task automatic txn(input int stall, input bit keep);
        int         w;
        logic [7:0] ey;
        logic [3:0] oh;
        drive();
        #1;
        w = model_winner();
        if (w < 0) begin
            chk("no_pending_in_model", 32'd0, 32'd1);
            return;
        end
        oh = 4'b0001 << w;
        last_grant = req_ready;
        chk("grant", {28'd0, req_ready}, {28'd0, oh});
        chk("idle_busy", {31'd0, busy}, 32'd0);
        ey = ref_op(ma[w], mb[w], mop[w]);
        rsp_ready = (stall == 0);
        @(posedge clk); #1;
        if (!keep) pend[w] = 1'b0;
        drive();
        #1;
        chk("exec_ready", {28'd0, req_ready}, 32'd0);
        chk("exec_busy", {31'd0, busy}, 32'd1);
        chk("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        chk("resp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("resp_y", {24'd0, rsp_y}, {24'd0, ey});
        chk("resp_id", {30'd0, rsp_id}, w);
        last_y  = rsp_y;
        last_id = rsp_id;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_y", {24'd0, rsp_y}, {24'd0, ey});
            chk("hold_id", {30'd0, rsp_id}, w);
            chk("hold_ready", {28'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_valid", {31'd0, rsp_valid}, 32'd0);
        chk("post_busy", {31'd0, busy}, 32'd0);
        chk("post_y_kept", {24'd0, rsp_y}, {24'd0, ey});
        mptr = (w + 1) % N;
    endtask

    logic [7:0] t2_exp [4] = '{8'hAF, 8'hA5, 8'hF5, 8'h0A};
    logic [1:0] t2_op  [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] t3_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        mptr      = 0;
        clear_model();
        drive();
        #1;
        // Reset values
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_y", {24'd0, rsp_y}, 32'd0);
        chk("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All four valid continuously from reset: grants 0,1,2,3,0
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b1;
            ma[i]   = 8'h11 * (i + 1);
            mb[i]   = 8'h5A;
            mop[i]  = 2'(i);
        end
        for (int t = 0; t < 5; t++) begin
            txn(0, 1'b1);
            chk("t3_order", {28'd0, last_grant}, {28'd0, t3_exp[t]});
            chk("t3_id", {30'd0, last_id}, t % N);
        end
        clear_model();
        drive();

        // Single request on req0
        pend[0] = 1'b1; ma[0] = 8'hF0; mb[0] = 8'h3C; mop[0] = 2'd0;
        txn(0, 1'b0);
        chk("t1_grant", {28'd0, last_grant}, 32'b0001);
        chk("t1_y", {24'd0, last_y}, 32'h30);
        chk("t1_id", {30'd0, last_id}, 32'd0);

        // Opcodes on req2
        for (int t = 0; t < 4; t++) begin
            pend[2] = 1'b1; ma[2] = 8'hAA; mb[2] = 8'h0F; mop[2] = t2_op[t];
            txn(0, 1'b0);
            chk("t2_y", {24'd0, last_y}, {24'd0, t2_exp[t]});
            chk("t2_id", {30'd0, last_id}, 32'd2);
        end

        // Backpressure with other requesters waiting
        pend[1] = 1'b1; ma[1] = 8'h3C; mb[1] = 8'hC3; mop[1] = 2'd1;
        pend[3] = 1'b1; ma[3] = 8'h81; mb[3] = 8'h18; mop[3] = 2'd2;
        txn(5, 1'b0);
        txn(0, 1'b0);

        // Pointer wrap: last grant to req3, then req0 and req3 contend
        pend[3] = 1'b1; ma[3] = 8'h0F; mb[3] = 8'hFF; mop[3] = 2'd3;
        txn(0, 1'b0);
        chk("t5_pre_id", {30'd0, last_id}, 32'd3);
        pend[0] = 1'b1; ma[0] = 8'h12; mb[0] = 8'h34; mop[0] = 2'd2;
        pend[3] = 1'b1; ma[3] = 8'h56; mb[3] = 8'h78; mop[3] = 2'd0;
        txn(0, 1'b0);
        chk("t5_wrap_grant", {28'd0, last_grant}, 32'b0001);
        txn(0, 1'b0);
        chk("t5_then_req3", {30'd0, last_id}, 32'd3);

        // Reset during EXEC
        pend[2] = 1'b1; ma[2] = 8'hFF; mb[2] = 8'hFF; mop[2] = 2'd0;
        drive();
        @(posedge clk); #1;
        pend[2] = 1'b0;
        drive();
        chk("t6_in_exec", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_y", {24'd0, rsp_y}, 32'd0);
        mptr = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t6_no_stale", {31'd0, rsp_valid}, 32'd0);
        chk("t6_idle", {31'd0, busy}, 32'd0);
        pend[1] = 1'b1; ma[1] = 8'hC0; mb[1] = 8'h0C; mop[1] = 2'd1;
        txn(0, 1'b0);
        chk("t6_id", {30'd0, last_id}, 32'd1);
        chk("t6_y", {24'd0, last_y}, 32'hCC);

        // Randomized traffic against the model
        for (int t = 0; t < 60; t++) begin
            bit any;
            any = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i] = 1'b1;
                    ma[i]   = 8'($urandom);
                    mb[i]   = 8'($urandom);
                    mop[i]  = 2'($urandom_range(0, 3));
                end
                any = any | pend[i];
            end
            if (!any) begin
                int j;
                j = $urandom_range(0, N - 1);
                pend[j] = 1'b1;
                ma[j]   = 8'($urandom);
                mb[j]   = 8'($urandom);
                mop[j]  = 2'($urandom_range(0, 3));
            end
            txn($urandom_range(0, 2), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
